rx_byte_buffer: RTL and testbench

- Downstream stage of the serial receiver: consumes its PDout/ParErr/PDready outputs in the system Clk domain.
- Synchronises PDready, detects each new frame and pushes the received byte into a show-ahead FIFO.
- Keeps a parity-error counter and a sticky overflow flag.
- Host logic drains bytes through a simple RdEn/RdData/Empty interface.

---
 rtl/rx_byte_buffer.sv | 112 +++++++++++
 tb/tb_rx_byte_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_buffer.sv
// Receive byte buffer: synchronises PDready, pushes each new frame into a show-ahead FIFO,
// and tracks parity errors and overflow. Optional macro RX_DROP_PARERR_EN discards errored bytes.
module rx_byte_buffer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int ERRW  = 8
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            PDready,
   input  logic [7:0]      PDout,
   input  logic            ParErr,
   input  logic            RdEn,
   input  logic            ClrStat,
   output logic [7:0]      RdData,
   output logic            Empty,
   output logic            Full,
   output logic [AW:0]     Count,
   output logic            Overflow,
   output logic [ERRW-1:0] ErrCount
);

   logic            r_s1, r_s2, r_s3;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_count;
   logic            r_ovf;
   logic [ERRW-1:0] r_errcnt;

   logic            w_nf;
   logic            w_full, w_empty;
   logic            w_keep;
   logic            w_wr, w_rd;
   logic            w_ovf_evt, w_err_evt;
   logic [AW:0]     w_count_nxt;

   // Two-flop synchroniser plus an edge-detect flop; one nf pulse per PDready rise.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= PDready;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_nf    = r_s2 & ~r_s3;
   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);

`ifdef RX_DROP_PARERR_EN
   assign w_keep = ~ParErr;
`else
   assign w_keep = 1'b1;
`endif

   // A full FIFO still accepts a byte when the same cycle pops the head.
   assign w_rd      = RdEn & ~w_empty;
   assign w_wr      = w_nf & w_keep & (~w_full | RdEn);
   assign w_ovf_evt = w_nf & w_keep & w_full & ~RdEn;
   assign w_err_evt = w_nf & ParErr;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= PDout;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
      end
   end

   // ClrStat wins over a same-cycle overflow or parity event.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_ovf    <= 1'b0;
         r_errcnt <= '0;
      end else if (ClrStat) begin
         r_ovf    <= 1'b0;
         r_errcnt <= '0;
      end else begin
         if (w_ovf_evt) r_ovf <= 1'b1;
         if (w_err_evt && (r_errcnt != '1)) r_errcnt <= r_errcnt + ERRW'(1);
      end
   end

   assign RdData   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign Empty    = w_empty;
   assign Full     = w_full;
   assign Count    = r_count;
   assign Overflow = r_ovf;
   assign ErrCount = r_errcnt;

endmodule

// File: tb/tb_rx_byte_buffer.sv
// Bench for rx_byte_buffer: directed and random frames/reads checked against a queue model.
module tb_rx_byte_buffer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int ERRW  = 8;
   localparam int ERRMAX = (1 << ERRW) - 1;
`ifdef RX_DROP_PARERR_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic            Clk = 1'b0;
   logic            Rst;
   logic            PDready;
   logic [7:0]      PDout;
   logic            ParErr;
   logic            RdEn;
   logic            ClrStat;
   logic [7:0]      RdData;
   logic            Empty;
   logic            Full;
   logic [AW:0]     Count;
   logic            Overflow;
   logic [ERRW-1:0] ErrCount;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the FIFO as a queue plus two status values.
   logic [7:0] m_q[$];
   bit         m_ovf;
   int         m_err;

   rx_byte_buffer #(.DEPTH(DEPTH), .AW(AW), .ERRW(ERRW)) dut (
      .Clk(Clk), .Rst(Rst), .PDready(PDready), .PDout(PDout), .ParErr(ParErr),
      .RdEn(RdEn), .ClrStat(ClrStat), .RdData(RdData), .Empty(Empty), .Full(Full),
      .Count(Count), .Overflow(Overflow), .ErrCount(ErrCount)
   );

   always #5 Clk = ~Clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"},  32'(Count), 32'(m_q.size()));
      check({tag, ".empty"},  32'(Empty), 32'(m_q.size() == 0));
      check({tag, ".full"},   32'(Full),  32'(m_q.size() == DEPTH));
      check({tag, ".rddata"}, 32'(RdData), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
      check({tag, ".ovf"},    32'(Overflow), 32'(m_ovf));
      check({tag, ".err"},    32'(ErrCount), 32'(m_err));
   endtask

   function automatic void model_frame(input logic [7:0] d, input logic pe, input bit rd_same);
      if (pe && m_err < ERRMAX) m_err++;
      if (rd_same && m_q.size() > 0) void'(m_q.pop_front());
      if (!(DROP && pe)) begin
         if (m_q.size() < DEPTH) m_q.push_back(d);
         else m_ovf = 1'b1;
      end
   endfunction

   // PDready rises before edge N; the byte is written at edge N+2.
   task automatic send_frame(input logic [7:0] d, input logic pe, input int unsigned hold, input bit rd_same);
      @(negedge Clk);
      PDout = d; ParErr = pe; PDready = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      if (rd_same) RdEn = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      RdEn = 1'b0;
      model_frame(d, pe, rd_same);
      repeat (hold) @(negedge Clk);
      PDready = 1'b0;
      repeat (3) @(negedge Clk);
      ParErr = 1'b0;
   endtask

   task automatic do_read(input string tag);
      @(negedge Clk);
      check({tag, ".head"}, 32'(RdData), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
      RdEn = 1'b1;
      @(negedge Clk);
      RdEn = 1'b0;
      if (m_q.size() > 0) void'(m_q.pop_front());
   endtask

   task automatic clr_stat();
      @(negedge Clk);
      ClrStat = 1'b1;
      @(negedge Clk);
      ClrStat = 1'b0;
      m_ovf = 1'b0;
      m_err = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) do_read("drain");
   endtask

   initial begin
      Rst = 1'b1; PDready = 1'b0; PDout = 8'h00; ParErr = 1'b0; RdEn = 1'b0; ClrStat = 1'b0;
      m_ovf = 1'b0; m_err = 0;
      #1;
      check_state("reset");
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      // Single frame: Empty falls only after the third edge.
      @(negedge Clk);
      PDout = 8'hA5; ParErr = 1'b0; PDready = 1'b1;
      @(posedge Clk); @(negedge Clk);
      check("lat.e1", 32'(Empty), 32'h1);
      @(posedge Clk); @(negedge Clk);
      check("lat.e2", 32'(Empty), 32'h1);
      @(posedge Clk); @(negedge Clk);
      check("lat.e3", 32'(Empty), 32'h0);
      check("lat.data", 32'(RdData), 32'hA5);
      check("lat.count", 32'(Count), 32'h1);
      m_q.push_back(8'hA5);
      PDready = 1'b0;
      repeat (3) @(negedge Clk);
      do_read("t1.rd");
      @(negedge Clk);
      check_state("t1.after");
      check("t1.rdzero", 32'(RdData), 32'h0);

      // Long PDready high stores exactly one byte.
      send_frame(8'h3C, 1'b0, 20, 1'b0);
      check_state("t2");
      check("t2.count", 32'(Count), 32'h1);
      drain();

      // Overfill, then read back in order.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1, 1'b0);
      check_state("t3.full");
      check("t3.ovf", 32'(Overflow), 32'h1);
      check("t3.cnt8", 32'(Count), 32'h8);
      for (int i = 1; i <= 8; i++) do_read("t3.rd");
      @(negedge Clk);
      check_state("t3.empty");

      // Full FIFO with a write and a read in the same cycle.
      clr_stat();
      for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b0, 1, 1'b0);
      send_frame(8'h77, 1'b0, 1, 1'b1);
      check_state("t4");
      check("t4.ovf", 32'(Overflow), 32'h0);
      for (int i = 0; i < DEPTH - 1; i++) do_read("t4.rd");
      @(negedge Clk);
      check("t4.last", 32'(RdData), 32'h77);
      do_read("t4.rdlast");
      @(negedge Clk);
      check_state("t4.empty");

      // Parity errors, clear, saturation.
      send_frame(8'hF0, 1'b1, 1, 1'b0);
      send_frame(8'hF1, 1'b1, 1, 1'b0);
      send_frame(8'hF2, 1'b1, 1, 1'b0);
      check("t5.err3", 32'(ErrCount), 32'h3);
      check("t5.cnt", 32'(Count), DROP ? 32'h0 : 32'h3);
      check_state("t5");
      clr_stat();
      check_state("t5.clr");
      drain();
      for (int i = 0; i < 300; i++) send_frame(8'(i), 1'b1, 0, 1'b0);
      check("t5.sat", 32'(ErrCount), 32'(ERRMAX));
      check_state("t5.sat");
      clr_stat();
      drain();

      // Randomised frames and reads.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 1) == 0)
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                       ($urandom_range(0, 3) == 0));
         else
            do_read("rnd.rd");
         @(negedge Clk);
         check_state("rnd");
      end

      // Reset with data stored and a frame in the synchroniser.
      clr_stat();
      drain();
      for (int i = 0; i < 5; i++) send_frame(8'h50 + 8'(i), 1'b0, 1, 1'b0);
      check("t6.cnt5", 32'(Count), 32'h5);
      @(negedge Clk);
      PDout = 8'hEE; PDready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      m_q.delete(); m_ovf = 1'b0; m_err = 0;
      check("t6.empty", 32'(Empty), 32'h1);
      check("t6.count", 32'(Count), 32'h0);
      PDready = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      repeat (5) @(negedge Clk);
      check_state("t6.after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
